result_drain: RTL
=================

# result_drain

Read-side counterpart to the result memory. Holds a 4-entry × 8-bit result buffer, written with the same address/write-enable/data write port the datapath uses for result storage. On a `start` pulse it streams entries 0..3 out in order over a valid/ready handshake, so results can be shipped off-chip or to a checker without a combinational read path into the datapath.

## Interface
- `DEPTH`, default 4: number of buffer entries. Must be a power of two.
- `WIDTH`, default 8: data width in bits.
- `ADDR_W`, default 2: address width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe from the datapath.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `WIDTH`  write data.
- `start`  in  1  begin a drain; single-cycle pulse or level.
- `out_data`  out  `WIDTH`  current beat.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  sink accepts the beat.
- `out_last`  out  1  current beat is the final beat.
- `busy`  out  1  drain in progress.
- `done`  out  1  one-cycle pulse after the final beat transfers.
- `wr_drop`  out  1  sticky flag: a write was issued while busy.

Reset and clock: reset `reset`, synchronous, active-high; clock `clk`.

## Operation
- Reset values:
  - `out_valid`, `out_last`, `busy`, `done`, `wr_drop` = 0.
  - `out_data` = 0.
  - All buffer entries = 0.
  - State = IDLE.
- Writes:
  - While not busy, `wr_en` writes `wr_data` to `mem[wr_addr]` at the clock edge.
  - While busy, writes are discarded and `wr_drop` sets to 1.
  - `wr_drop` clears only on an accepted `start` or on reset.
- States:
  - IDLE: `start`=1 → SEND. Beat pointer = 0, `out_data` loaded with `mem[0]`, `wr_drop` cleared.
  - SEND: `out_valid`=1, `busy`=1.
    - Transfer occurs on any edge where `out_valid` && `out_ready`.
    - On a non-final transfer, the pointer increments and `out_data` loads the next entry on the same edge.
    - On the final transfer → DONE.
  - DONE: `done`=1, `busy`=0, `out_valid`=0, for exactly one cycle, then → IDLE.
- Beat ordering:
  - Beats are sent in address order 0..`DEPTH`-1.
  - `out_last`=1 only while the final beat is presented.
  - The pointer never wraps within one drain.
- Stall rules:
  - `out_data` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never deasserts before its transfer, except on reset.
- Ignored `start`:
  - In SEND or DONE, `start` has no effect.
  - A `start` held high through DONE begins a new drain from IDLE on the following edge.
- Simultaneous `wr_en` and `start` in IDLE: the write lands first, so beat 0 reflects the write if `wr_addr`=0.
- Reset mid-drain: on the next edge, state = IDLE, `out_valid`=0, and the buffer is cleared.

## Timing
- Latency: `start` sampled at edge N gives `out_valid`=1 with beat 0 after edge N.
- Throughput: with `out_ready` held at 1, one beat per cycle.
- With `out_ready` held at 1 and the macro undefined:
  - 4 beats take 4 cycles.
  - `done` is high in cycle 5.
  - IDLE is reached in cycle 6.
- All outputs are registered. There is no combinational path from `out_ready` to `out_valid` or to `out_data`.

## Configuration
- `RESULT_DRAIN_CHECKSUM_EN`:
  - Defined: one extra beat is appended after entry `DEPTH`-1. It carries the sum of all transmitted entries modulo 2^`WIDTH`.
  - With the macro defined, `out_last` marks the checksum beat, not entry `DEPTH`-1.
  - The checksum accumulates from the values actually sent.
- Undefined: exactly `DEPTH` beats are sent, and no accumulator exists.

## Test plan
- Basic drain:
  - Stimulus: write 0x11, 0x22, 0x33, 0x44 to addresses 0..3; pulse `start`; hold `out_ready`=1.
  - Required: beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles; `out_last` only on 0x44; one `done` pulse.
- Backpressure:
  - Stimulus: same data; `out_ready` low for 3 cycles on beat 1.
  - Required: `out_data`=0x22 and `out_valid`=1 held stable throughout the stall; no beat is skipped or duplicated.
- Write while busy:
  - Stimulus: during SEND, write 0xFF to address 3.
  - Required: final beat is still 0x44; `wr_drop`=1; the next `start` clears `wr_drop`.
- Write and start together:
  - Stimulus: in IDLE, `wr_en`=1 with addr 0 and data 0xA5, plus `start`=1, in the same cycle.
  - Required: beat 0 = 0xA5.
- Reset mid-drain:
  - Stimulus: assert `reset` after beat 1 transfers.
  - Required: `out_valid`=0, `busy`=0 next cycle; a new drain without writes outputs 0x00 ×4.
- Checksum (macro defined):
  - Stimulus: data 0x80, 0x80, 0x01, 0x02.
  - Required: 5 beats; the fifth beat is 0x03 (wraps mod 256) with `out_last`=1.

Source files
------------

// File: rtl/result_drain_if.sv
// Handshake bundle for result_drain: datapath write port, drain start, stream output and status.
interface result_drain_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              start;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              wr_drop;

   modport master (
      output wr_en, wr_addr, wr_data, start, out_ready,
      input  out_data, out_valid, out_last, busy, done, wr_drop
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, out_ready,
      output out_data, out_valid, out_last, busy, done, wr_drop
   );
endinterface

// File: rtl/result_drain.sv
// Result buffer that streams entries 0..DEPTH-1 over valid/ready on a start request.
// Define RESULT_DRAIN_CHECKSUM_EN to append a mod-2^WIDTH sum beat after the last entry.
module result_drain #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2
) (
   input logic           clk,
   input logic           reset,
   result_drain_if.slave bus
);
   localparam int unsigned PTR_W = ADDR_W + 1;
`ifdef RESULT_DRAIN_CHECKSUM_EN
   localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(DEPTH);
`else
   localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(DEPTH - 1);
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [1:0]       r_state;
   logic [PTR_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_out_last;
   logic             r_busy;
   logic             r_done;
   logic             r_wr_drop;

   logic [1:0]       w_state_nxt;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [PTR_W-1:0] w_ptr_inc;
   logic [WIDTH-1:0] w_data_nxt;
   logic             w_valid_nxt;
   logic             w_last_nxt;
   logic             w_drop_nxt;
   logic             w_xfer;
   logic             w_mem_wr;

`ifdef RESULT_DRAIN_CHECKSUM_EN
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] w_sum_nxt;
`endif

   assign w_xfer    = r_out_valid && bus.out_ready;
   assign w_mem_wr  = bus.wr_en && !r_busy;
   assign w_ptr_inc = r_ptr + PTR_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_data_nxt  = r_out_data;
      w_valid_nxt = r_out_valid;
      w_last_nxt  = r_out_last;
      w_drop_nxt  = r_wr_drop;
`ifdef RESULT_DRAIN_CHECKSUM_EN
      w_sum_nxt   = r_sum;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_SEND;
               w_ptr_nxt   = '0;
               w_valid_nxt = 1'b1;
               w_last_nxt  = (LAST_BEAT == '0);
               w_drop_nxt  = 1'b0;
               // A same-cycle write to entry 0 must be visible in the first beat.
               w_data_nxt  = (bus.wr_en && (bus.wr_addr == '0)) ? bus.wr_data : r_mem[0];
`ifdef RESULT_DRAIN_CHECKSUM_EN
               w_sum_nxt   = '0;
`endif
            end
         end
         S_SEND: begin
            if (bus.wr_en) begin
               w_drop_nxt = 1'b1;
            end
            if (w_xfer) begin
               if (r_out_last) begin
                  w_state_nxt = S_DONE;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
               end else begin
                  w_ptr_nxt  = w_ptr_inc;
                  w_last_nxt = (w_ptr_inc == LAST_BEAT);
`ifdef RESULT_DRAIN_CHECKSUM_EN
                  w_sum_nxt  = r_sum + r_out_data;
                  w_data_nxt = (w_ptr_inc == PTR_W'(DEPTH)) ? w_sum_nxt
                                                            : r_mem[w_ptr_inc[ADDR_W-1:0]];
`else
                  w_data_nxt = r_mem[w_ptr_inc[ADDR_W-1:0]];
`endif
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wr_drop   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_out_data  <= w_data_nxt;
         r_out_valid <= w_valid_nxt;
         r_out_last  <= w_last_nxt;
         r_busy      <= (w_state_nxt == S_SEND);
         r_done      <= (w_state_nxt == S_DONE);
         r_wr_drop   <= w_drop_nxt;
      end
   end

`ifdef RESULT_DRAIN_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sum <= '0;
      end else begin
         r_sum <= w_sum_nxt;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_mem_wr) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.wr_drop   = r_wr_drop;
endmodule
